// File: rtl/fifo_unpacker_pkg.sv
// Shared definitions for the FIFO word-to-byte unpacker: state encoding and
// word/byte geometry.
package fifo_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01
  } state_t;

  localparam int WORD_BYTES = 8;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

endpackage

// File: rtl/fifo_unpacker_cnt.sv
// Byte-position counter for the unpacker. It flags the last byte of a word
// so the FSM can decide between reload and return-to-idle.
module unpack_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] cnt,
  output logic       last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (inc) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign last = (cnt == 3'd7);

endmodule

// File: rtl/fifo_unpacker.sv
// Pops 64-bit words from a FIFO head and streams them out as bytes. The next
// word is popped during the last-byte transfer so words run back-to-back.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  output logic              fifo_pop,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic [15:0]       words_done,
  output logic              err
);

  // Byte stream handshake: a byte moves when byte_valid and byte_ready are both
  // high on a rising edge; byte_out is held unchanged while byte_ready is low.
  state_t              state, next_state;
  logic [WORD_W-1:0]   shreg;
  logic [2:0]          bcnt;
  logic                bcnt_last;
  logic                pop_req, load, shift, cnt_inc, cnt_clr, done_inc, illegal;

  unpack_cnt u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (bcnt),
    .last (bcnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop_req    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    done_inc   = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_req    = 1'b1;
          load       = 1'b1;
          cnt_clr    = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (byte_ready) begin
          if (!bcnt_last) begin
            shift   = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            done_inc = 1'b1;
            if (!fifo_empty) begin
              pop_req = 1'b1;
              load    = 1'b1;
              cnt_clr = 1'b1;
            end else begin
              next_state = ST_IDLE;
            end
          end
        end
      end
      default: begin
        illegal    = 1'b1;
        next_state = ST_IDLE;
      end
    endcase
  end

  // Reset overrides the pop strobe so the FIFO is not drained while held in reset.
  assign fifo_pop = pop_req & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= fifo_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end else begin
        shreg <= {{BYTE_W{1'b0}}, shreg[WORD_W-1:BYTE_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_done <= 16'd0;
      err        <= 1'b0;
    end else begin
      if (done_inc) begin
        words_done <= words_done + 16'd1;
      end
      if (illegal || (fifo_empty && fifo_full)) begin
        err <= 1'b1;
      end
    end
  end

  assign byte_valid = (state == ST_SEND);
  assign busy       = (state == ST_SEND);
  assign byte_out   = MSB_FIRST ? shreg[WORD_W-1 -: BYTE_W] : shreg[BYTE_W-1:0];

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker: a queue models the FIFO, a scoreboard
// holds the expected byte stream; instance 0 is LSB-first, instance 1 MSB-first.
module tb_fifo_unpacker;

  logic        clk;
  logic        rst;
  logic [63:0] fifo_data  [2];
  logic        fifo_empty [2];
  logic        fifo_full  [2];
  logic        fifo_pop   [2];
  logic [7:0]  byte_out   [2];
  logic        byte_valid [2];
  logic        byte_ready [2];
  logic        busy       [2];
  logic [15:0] words_done [2];
  logic        err        [2];

  fifo_unpacker #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .fifo_data(fifo_data[0]), .fifo_empty(fifo_empty[0]),
    .fifo_full(fifo_full[0]), .fifo_pop(fifo_pop[0]), .byte_out(byte_out[0]),
    .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]), .busy(busy[0]),
    .words_done(words_done[0]), .err(err[0])
  );

  fifo_unpacker #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .fifo_data(fifo_data[1]), .fifo_empty(fifo_empty[1]),
    .fifo_full(fifo_full[1]), .fifo_pop(fifo_pop[1]), .byte_out(byte_out[1]),
    .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]), .busy(busy[1]),
    .words_done(words_done[1]), .err(err[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          sel = 0;
  logic        full_force = 1'b0;
  logic [63:0] fifo_q [$];
  logic [7:0]  exp_q  [$];
  logic        pend_pop = 1'b0;
  int          cyc = 0;
  int          pop_cnt, vcnt, first_v, last_v, bidx;
  logic        seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    fifo_q.push_back(w);
    for (int b = 0; b < 8; b++) begin
      if (sel == 1) exp_q.push_back(w[63-8*b -: 8]);
      else          exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic clear_track();
    pop_cnt = 0; vcnt = 0; first_v = 0; last_v = 0; seen = 1'b0;
  endtask

  // Drive one cycle at the falling edge, sample 1 ns later, score transfers/pops.
  task automatic tick(input logic rdy);
    logic xfer;
    logic [7:0] e;
    @(negedge clk);
    if (pend_pop) begin
      if (fifo_q.size() != 0) fifo_q.delete(0);
      pend_pop = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = 1'b1; fifo_full[i] = 1'b0; fifo_data[i] = '0; byte_ready[i] = 1'b0;
    end
    fifo_empty[sel] = (fifo_q.size() == 0);
    fifo_data[sel]  = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
    fifo_full[sel]  = (fifo_q.size() == 4) || full_force;
    byte_ready[sel] = rdy;
    #1;
    cyc++;
    xfer = byte_valid[sel] && byte_ready[sel];
    if (byte_valid[sel]) begin
      if (!seen) first_v = cyc;
      seen = 1'b1; last_v = cyc; vcnt++;
    end
    if (fifo_pop[sel]) begin
      check("pop_not_empty", fifo_empty[sel], 1'b0);
      if (byte_valid[sel]) check("pop_at_byte7", {xfer, bidx == 7}, 2'b11);
      pop_cnt++;
      pend_pop = 1'b1;
    end
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("byte_out", byte_out[sel], e);
      end
      bidx = (bidx + 1) % 8;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1'b1);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    tick(1'b1);
    check("idle_after", busy[sel], 1'b0);
  endtask

  initial begin
    int t_fall;
    logic [15:0] wd0;
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = 1'b1; fifo_full[i] = 1'b0; fifo_data[i] = '0; byte_ready[i] = 1'b0;
    end
    bidx = 0;
    clear_track();
    rst = 1'b1;
    tick(1'b1);
    tick(1'b1);
    check("rst_valid", byte_valid[0], 1'b0);
    check("rst_byte_out", byte_out[0], 8'h00);
    check("rst_busy", busy[0], 1'b0);
    check("rst_words_done", words_done[0], 16'd0);
    check("rst_err", err[0], 1'b0);
    check("rst_pop", fifo_pop[0], 1'b0);
    rst = 1'b0;

    // single word
    clear_track();
    push_word(64'h8877665544332211);
    tick(1'b1);
    t_fall = cyc;
    check("single_pop_on_fall", pop_cnt, 1);
    check("single_no_valid_yet", byte_valid[0], 1'b0);
    drain(20);
    check("single_latency", first_v, t_fall + 1);
    check("single_vcnt", vcnt, 8);
    check("single_span", last_v - first_v, 7);
    check("single_pops", pop_cnt, 1);
    check("single_words_done", words_done[0], 16'd1);

    // back-to-back, FIFO preloaded with four words
    clear_track();
    wd0 = words_done[0];
    push_word(64'h0706050403020100);
    push_word(64'hF0E0D0C0B0A09080);
    push_word(64'h1122334455667788);
    push_word(64'hDEADBEEFCAFEF00D);
    drain(60);
    check("b2b_vcnt", vcnt, 32);
    check("b2b_span", last_v - first_v, 31);
    check("b2b_pops", pop_cnt, 4);
    check("b2b_words_done", words_done[0] - wd0, 16'd4);

    // backpressure on the fifth byte
    clear_track();
    push_word(64'h0123456789ABCDEF);
    for (int i = 0; i < 5; i++) tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      check("bp_hold_byte", byte_out[0], 8'h67);
      check("bp_hold_valid", byte_valid[0], 1'b1);
      check("bp_no_pop", fifo_pop[0], 1'b0);
    end
    drain(20);
    check("bp_pops", pop_cnt, 1);
    check("bp_words_done", words_done[0] - wd0, 16'd5);

    // MSB-first instance
    sel = 1;
    bidx = 0;
    clear_track();
    push_word(64'h8877665544332211);
    drain(20);
    check("msb_vcnt", vcnt, 8);
    check("msb_words_done", words_done[1], 16'd1);
    sel = 0;
    bidx = 0;

    // reset in the middle of a word, second word waiting in the FIFO
    clear_track();
    push_word(64'hA1A2A3A4A5A6A7A8);
    push_word(64'hB1B2B3B4B5B6B7B8);
    for (int i = 0; i < 4; i++) tick(1'b1);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", byte_valid[0], 1'b0);
    check("midrst_pop", fifo_pop[0], 1'b0);
    check("midrst_words_done", words_done[0], 16'd0);
    exp_q.delete();
    bidx = 0;
    tick(1'b1);
    check("midrst_pop_held", fifo_pop[0], 1'b0);
    check("midrst_busy", busy[0], 1'b0);
    fifo_q.delete();
    pend_pop = 1'b0;
    tick(1'b1);
    rst = 1'b0;

    // empty and full together
    tick(1'b1);
    check("err_clear_before", err[0], 1'b0);
    full_force = 1'b1;
    tick(1'b1);
    full_force = 1'b0;
    tick(1'b1);
    check("err_set", err[0], 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1);
    check("err_sticky", err[0], 1'b1);
    rst = 1'b1;
    #1;
    check("err_cleared_by_rst", err[0], 1'b0);
    tick(1'b1);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
